cnn_result_argmax: RTL and testbench



---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_result_argmax.sv | 133 +++++++++++++
 tb/tb_cnn_result_argmax.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN accelerator result path.
package cnn_pkg;

  localparam int CNN_N_OUT      = 10;
  localparam int CNN_DATA_W     = 16;
  localparam int CNN_OUT_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    HOLD
  } argmax_state_t;

  typedef logic signed [CNN_DATA_W-1:0] score_t;

endpackage

// File: rtl/cnn_result_argmax.sv
// Scans the CNN output score RAM after ap_done and presents the arg-max class on a valid/ready port.
// Define CNN_ARGMAX_SCORE_EN to also export the winning score on result_score.
module cnn_result_argmax
  import cnn_pkg::*;
#(
  parameter int N_OUT  = CNN_N_OUT,
  parameter int DATA_W = CNN_DATA_W,
  parameter int ADDR_W = CNN_OUT_ADDR_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              cnn_ap_done,
  output logic              busy,
  output logic              overrun,
  output logic              score_ce,
  output logic [ADDR_W-1:0] score_address,
  input  logic [DATA_W-1:0] score_q,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [ADDR_W-1:0] result_class
`ifdef CNN_ARGMAX_SCORE_EN
  ,
  output logic [DATA_W-1:0] result_score
`endif
);

  // One extra counter bit keeps N_OUT = 2^ADDR_W from aliasing onto address 0.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(N_OUT - 1);

  argmax_state_t            r_state;
  argmax_state_t            w_state_next;
  logic [ADDR_W:0]          r_addr_cnt;
  logic                     r_rd_vld;
  logic [ADDR_W-1:0]        r_rd_idx;
  logic signed [DATA_W-1:0] r_max_score;
  logic [ADDR_W-1:0]        r_max_idx;
  logic [ADDR_W-1:0]        r_result_class;
  logic                     r_overrun;
  logic signed [DATA_W-1:0] w_sample;
  logic                     w_take;

  assign w_sample = score_q;
  // Index 0 seeds the running max; later samples must be strictly greater so ties stay low.
  assign w_take   = r_rd_vld && ((r_rd_idx == '0) || (w_sample > r_max_score));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    busy          = 1'b0;
    score_ce      = 1'b0;
    score_address = '0;
    result_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cnn_ap_done) w_state_next = READ;
      end
      READ: begin
        busy          = 1'b1;
        score_ce      = 1'b1;
        score_address = r_addr_cnt[ADDR_W-1:0];
        if (r_addr_cnt == LAST_ADDR) w_state_next = DRAIN;
      end
      DRAIN: begin
        busy         = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_addr_cnt     <= '0;
      r_rd_vld       <= 1'b0;
      r_rd_idx       <= '0;
      r_max_score    <= '0;
      r_max_idx      <= '0;
      r_result_class <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == READ);
      r_rd_idx <= r_addr_cnt[ADDR_W-1:0];
      if (r_state == READ) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
      end else begin
        r_addr_cnt <= '0;
      end
      if (w_take) begin
        r_max_score <= w_sample;
        r_max_idx   <= r_rd_idx;
      end
      // The last sample arrives during DRAIN, so fold it in directly rather than waiting a cycle.
      if (r_state == DRAIN) begin
        r_result_class <= w_take ? r_rd_idx : r_max_idx;
      end
      if (cnn_ap_done && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign result_class = r_result_class;
  assign overrun      = r_overrun;

`ifdef CNN_ARGMAX_SCORE_EN
  logic [DATA_W-1:0] r_result_score;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_result_score <= '0;
    end else if (r_state == DRAIN) begin
      r_result_score <= w_take ? w_sample : r_max_score;
    end
  end

  assign result_score = r_result_score;
`else
  // Score stays internal to the comparator; no exported copy is kept.
`endif

endmodule

// File: tb/tb_cnn_result_argmax.sv
`timescale 1ns/1ps
// Scoreboard bench for cnn_result_argmax: directed score sets, one N_OUT=10 and one N_OUT=16 instance.
module tb_cnn_result_argmax;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        done10 = 1'b0, ready10 = 1'b0;
  logic        busy10, ovr10, ce10, valid10;
  logic [3:0]  addr10, cls10;
  logic [15:0] q10 = '0;

  logic        done16 = 1'b0, ready16 = 1'b0;
  logic        busy16, ovr16, ce16, valid16;
  logic [3:0]  addr16, cls16;
  logic [15:0] q16 = '0;

`ifdef CNN_ARGMAX_SCORE_EN
  logic [15:0] sc10, sc16;
`endif

  logic [15:0] mem [16];
  int          cnt16 [16];
  logic        clr16 = 1'b0;

  // Score RAM second read port model: one-cycle registered read per instance.
  always @(posedge clk) begin
    if (ce10) q10 <= mem[addr10];
    if (ce16) q16 <= mem[addr16];
    for (int i = 0; i < 16; i++) begin
      if (clr16) cnt16[i] <= 0;
      else if (ce16 && addr16 == 4'(i)) cnt16[i] <= cnt16[i] + 1;
    end
  end

  cnn_result_argmax #(.N_OUT(10), .DATA_W(16), .ADDR_W(4)) u_dut10 (
    .ap_clk        (clk),
    .ap_rst        (rst),
    .cnn_ap_done   (done10),
    .busy          (busy10),
    .overrun       (ovr10),
    .score_ce      (ce10),
    .score_address (addr10),
    .score_q       (q10),
    .result_valid  (valid10),
    .result_ready  (ready10),
    .result_class  (cls10)
`ifdef CNN_ARGMAX_SCORE_EN
    ,
    .result_score  (sc10)
`endif
  );

  cnn_result_argmax #(.N_OUT(16), .DATA_W(16), .ADDR_W(4)) u_dut16 (
    .ap_clk        (clk),
    .ap_rst        (rst),
    .cnn_ap_done   (done16),
    .busy          (busy16),
    .overrun       (ovr16),
    .score_ce      (ce16),
    .score_address (addr16),
    .score_q       (q16),
    .result_valid  (valid16),
    .result_ready  (ready16),
    .result_class  (cls16)
`ifdef CNN_ARGMAX_SCORE_EN
    ,
    .result_score  (sc16)
`endif
  );

  typedef struct packed {
    logic [3:0]  cls;
    logic [15:0] score;
  } exp_t;

  exp_t exp10[$];
  exp_t exp16[$];
  exp_t e10, e16;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitors: a transfer happens on the coming edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && valid10 && ready10) begin
      if (exp10.size() == 0) begin
        chk("dut10_unexpected_result", 1, 0);
      end else begin
        e10 = exp10.pop_front();
        $display("dut10 result class=%0d (want %0d)", cls10, e10.cls);
        chk("dut10_class", 32'(cls10), 32'(e10.cls));
`ifdef CNN_ARGMAX_SCORE_EN
        chk("dut10_score", 32'(sc10), 32'(e10.score));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid16 && ready16) begin
      if (exp16.size() == 0) begin
        chk("dut16_unexpected_result", 1, 0);
      end else begin
        e16 = exp16.pop_front();
        $display("dut16 result class=%0d (want %0d)", cls16, e16.cls);
        chk("dut16_class", 32'(cls16), 32'(e16.cls));
`ifdef CNN_ARGMAX_SCORE_EN
        chk("dut16_score", 32'(sc16), 32'(e16.score));
`endif
      end
    end
  end

  task automatic pulse10();
    @(posedge clk); #1 done10 = 1'b1;
    @(posedge clk); #1 done10 = 1'b0;
  endtask

  task automatic pulse16();
    @(posedge clk); #1 done16 = 1'b1;
    @(posedge clk); #1 done16 = 1'b0;
  endtask

  // Entered just after the edge that sampled done; counts edges until valid shows.
  task automatic wait10(input string name, input int exp_n);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b1;
    while (!valid10 && n < 60) begin
      if (n < 10) ok &= (ce10 === 1'b1) && (addr10 == n[3:0]);
      else        ok &= (ce10 === 1'b0) && (addr10 == 4'd0);
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_n));
    chk({name, "_addr_seq"}, 32'(ok), 32'd1);
  endtask

  task automatic wait16(input string name, input int exp_n);
    int n;
    n = 0;
    while (!valid16 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  task automatic chk_rst10(input string name);
    chk({name, "_busy"},    32'(busy10),  32'd0);
    chk({name, "_overrun"}, 32'(ovr10),   32'd0);
    chk({name, "_ce"},      32'(ce10),    32'd0);
    chk({name, "_addr"},    32'(addr10),  32'd0);
    chk({name, "_valid"},   32'(valid10), 32'd0);
    chk({name, "_class"},   32'(cls10),   32'd0);
`ifdef CNN_ARGMAX_SCORE_EN
    chk({name, "_score"},   32'(sc10),    32'd0);
`endif
  endtask

  logic [15:0] s1 [10];
  bit          stable;
  bit          once;

  initial begin
    s1 = '{16'h0005, 16'hFFFD, 16'h000C, 16'h0007, 16'h000C,
           16'h0000, 16'hFF9C, 16'h000B, 16'h0001, 16'h0002};
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_rst10("reset");
    chk("reset_busy16", 32'(busy16), 32'd0);
    rst = 1'b0;

    // Test 1: mixed scores, tie between 2 and 4 goes to 2
    for (int i = 0; i < 10; i++) mem[i] = s1[i];
    exp10.push_back('{cls: 4'd2, score: 16'h000C});
    ready10 = 1'b1;
    pulse10();
    wait10("t1", 11);
    repeat (2) @(posedge clk);
    #1;

    // Test 2: all most-negative scores
    for (int i = 0; i < 10; i++) mem[i] = 16'h8000;
    exp10.push_back('{cls: 4'd0, score: 16'h8000});
    pulse10();
    wait10("t2", 11);
    repeat (2) @(posedge clk);
    #1;

    // Test 3: consumer stalls 20 cycles, done arrives during HOLD
    for (int i = 0; i < 10; i++) mem[i] = 16'hFFCE;
    mem[6] = 16'hFFFF;
    exp10.push_back('{cls: 4'd6, score: 16'hFFFF});
    ready10 = 1'b0;
    pulse10();
    wait10("t3", 11);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) done10 = 1'b1;
      if (i == 6) done10 = 1'b0;
      stable &= (valid10 === 1'b1) && (busy10 === 1'b1) && (cls10 == 4'd6) && (ce10 === 1'b0);
      @(posedge clk); #1;
    end
    chk("t3_hold_stable", 32'(stable), 32'd1);
    chk("t3_overrun", 32'(ovr10), 32'd1);
    ready10 = 1'b1;
    @(posedge clk); #1;
    chk("t3_valid_fall", 32'(valid10), 32'd0);
    chk("t3_busy_fall", 32'(busy10), 32'd0);

    // Test 5: reset in cycle t+5 of a scan, then a fresh scan
    for (int i = 0; i < 10; i++) mem[i] = s1[i];
    pulse10();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_rst10("abort");
    exp10.push_back('{cls: 4'd2, score: 16'h000C});
    pulse10();
    wait10("t5", 11);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_overrun_clear", 32'(ovr10), 32'd0);

    // Test 4: N_OUT=16, max at index 9 then at index 15
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[9] = 16'h7FFF;
    ready16 = 1'b1;
    exp16.push_back('{cls: 4'd9, score: 16'h7FFF});
    pulse16();
    wait16("t4a", 17);
    repeat (2) @(posedge clk);
    #1;
    mem[9]  = 16'h0000;
    mem[15] = 16'h7FFF;
    clr16 = 1'b1;
    @(posedge clk); #1;
    clr16 = 1'b0;
    exp16.push_back('{cls: 4'd15, score: 16'h7FFF});
    pulse16();
    wait16("t4b", 17);
    repeat (2) @(posedge clk);
    #1;
    once = 1'b1;
    for (int i = 0; i < 16; i++) once &= (cnt16[i] == 1);
    chk("t4b_addr_once", 32'(once), 32'd1);
    chk("t4_overrun16", 32'(ovr16), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", 32'(exp10.size() + exp16.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
